// File: rtl/serial_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_pkg
// Description : Shared definitions for the bit-serial ALU controller:
//               operation encodings, FSM state type, slice control word
//               field positions and a helper that packs the control word.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_alu_pkg;

    // Operation encodings carried on the op port and in slice_ctrl[4:3]
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Field positions inside the 5-bit slice control word
    localparam int c_ctrl_op_hi = 4;
    localparam int c_ctrl_op_lo = 3;
    localparam int c_ctrl_inv   = 2;
    localparam int c_ctrl_cin   = 1;
    localparam int c_ctrl_shl   = 0;

    function automatic logic [4:0] pack_ctrl(input logic [1:0] op,
                                             input logic       inv,
                                             input logic       cin,
                                             input logic       shl);
        logic [4:0] w_ctrl;
        w_ctrl                            = '0;
        w_ctrl[c_ctrl_op_hi:c_ctrl_op_lo] = op;
        w_ctrl[c_ctrl_inv]                = inv;
        w_ctrl[c_ctrl_cin]                = cin;
        w_ctrl[c_ctrl_shl]                = shl;
        return w_ctrl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_bit_slice.sv
`default_nettype none
// ============================================================================
// Module      : alu_bit_slice
// Description : One-bit ALU slice. Full adder for add/sub (operand b is
//               inverted for sub, the controller supplies carry-in = 1 on the
//               first bit), and/or with optional output inversion.
// Ports       : a, b  - operand bits
//               ctrl  - [4:3] op, [2] invert, [1] carry-in, [0] shift
//               y     - sum / logic result bit
//               cout  - carry-out (0 for logic ops)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_bit_slice
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [4:0] ctrl,
    output logic       y,
    output logic       cout
);

    logic [1:0] w_op;
    logic       w_inv;
    logic       w_cin;
    logic       w_b;

    // Shifting only changes where the controller stores the bit, so the
    // slice itself never looks at it.
    logic       w_unused_shl;
    assign w_unused_shl = ctrl[c_ctrl_shl];

    assign w_op  = ctrl[c_ctrl_op_hi:c_ctrl_op_lo];
    assign w_inv = ctrl[c_ctrl_inv];
    assign w_cin = ctrl[c_ctrl_cin];
    assign w_b   = (w_op == OP_SUB) ? ~b : b;

    always_comb begin
        y    = 1'b0;
        cout = 1'b0;
        unique case (w_op)
            OP_ADD, OP_SUB: begin
                y    = a ^ w_b ^ w_cin;
                cout = (a & w_b) | (a & w_cin) | (w_b & w_cin);
            end
            OP_AND:  y = (a & b) ^ w_inv;
            default: y = (a | b) ^ w_inv;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_ctrl
// Description : Bit-serial ALU controller. Accepts one request in IDLE,
//               processes one bit per cycle LSB first through a single
//               alu_bit_slice, then presents the result and flags in DONE
//               until the consumer takes them.
// Ports       : clk, reset (async, active-high)
//               req_valid/req_ready, op, invert, A, B [, shl] - request
//               rsp_valid/rsp_ready, result, carry, overflow, iszero,
//               greaterthan - response
//               slice_ctrl - control word presented to the bit slice
// Config      : SERIAL_ALU_SHIFT_EN adds the shl input (shift result left
//               by one, bit WIDTH-1 goes to carry). Undefined: no shift.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       op,
    input  logic             invert,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ALU_SHIFT_EN
    input  logic             shl,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             iszero,
    output logic             greaterthan,
    output logic [4:0]       slice_ctrl
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_op;
    logic               r_inv;
    logic               r_shl;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_cy;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_ovf;
    logic               r_zero;
    logic               r_gt;

    logic               w_shl_in;
    logic               w_accept;
    logic               w_last;
    logic               w_arith;
    logic               w_a_bit;
    logic               w_b_bit;
    logic               w_y;
    logic               w_cout;
    logic [WIDTH-1:0]   w_result_next;

`ifdef SERIAL_ALU_SHIFT_EN
    assign w_shl_in = shl;
`else
    assign w_shl_in = 1'b0;
`endif

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == c_last);
    assign w_arith  = (r_op == OP_ADD) || (r_op == OP_SUB);
    assign w_a_bit  = r_a[r_cnt];
    assign w_b_bit  = r_b[r_cnt];

    alu_bit_slice u_slice (
        .a    (w_a_bit),
        .b    (w_b_bit),
        .ctrl (slice_ctrl),
        .y    (w_y),
        .cout (w_cout)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        slice_ctrl   = '0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                slice_ctrl = pack_ctrl(r_op, r_inv, r_cy, r_shl);
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result placement: the slice bit lands at the current index, or one
    // above it when shifting (the top bit then falls off into carry).
    // ------------------------------------------------------------------
    always_comb begin
        w_result_next = r_result;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == int'(r_cnt) + int'(r_shl)) begin
                w_result_next[i] = w_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= OP_ADD;
            r_inv    <= 1'b0;
            r_shl    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_cy     <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_gt     <= 1'b0;
        end else if (w_accept) begin
            r_op     <= op;
            r_inv    <= invert;
            r_shl    <= w_shl_in;
            r_a      <= A;
            r_b      <= B;
            r_cnt    <= '0;
            // Subtraction is A + ~B + 1: the +1 enters as the first carry-in
            r_cy     <= (op == OP_SUB);
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_gt     <= 1'b0;
        end else if (r_state == RUN) begin
            r_cnt    <= r_cnt + 1'b1;
            r_result <= w_result_next;
            r_cy     <= w_cout;
            // Higher bits override lower ones, so the last differing bit
            // processed (the most significant) decides the comparison.
            r_gt     <= (w_a_bit & ~w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_gt);
            if (w_last) begin
                r_zero  <= (w_result_next == '0);
                r_carry <= r_shl ? w_y : (w_arith & w_cout);
                r_ovf   <= w_arith & (r_cy ^ w_cout);
            end
        end
    end

    assign result      = r_result;
    assign carry       = r_carry;
    assign overflow    = r_ovf;
    assign iszero      = r_zero;
    assign greaterthan = r_gt;

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_alu_ctrl
// Description : Self-checking bench for serial_alu_ctrl (WIDTH = 8):
//               directed vector table, randomized operations against an
//               arithmetic reference model, DONE back-pressure and
//               mid-operation reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_alu_ctrl;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       z;
        logic       g;
    } out_t;

    typedef struct {
        logic [1:0] op;
        logic       inv;
        logic [7:0] a;
        logic [7:0] b;
        int         stall;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] op;
    logic       invert;
    logic [7:0] A;
    logic [7:0] B;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] result;
    logic       carry;
    logic       overflow;
    logic       iszero;
    logic       greaterthan;
    logic [4:0] slice_ctrl;
`ifdef SERIAL_ALU_SHIFT_EN
    logic       shl;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .op          (op),
        .invert      (invert),
        .A           (A),
        .B           (B),
`ifdef SERIAL_ALU_SHIFT_EN
        .shl         (shl),
`endif
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .result      (result),
        .carry       (carry),
        .overflow    (overflow),
        .iszero      (iszero),
        .greaterthan (greaterthan),
        .slice_ctrl  (slice_ctrl)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model from plain arithmetic
    function automatic out_t model(input logic [1:0] o, input logic inv,
                                   input logic [7:0] a, input logic [7:0] b,
                                   input logic sh);
        out_t       r;
        logic [8:0] s;
        logic [7:0] raw;
        r   = '0;
        raw = '0;
        s   = '0;
        case (o)
            2'd0: begin
                s   = {1'b0, a} + {1'b0, b};
                raw = s[7:0];
                r.c = s[8];
                r.v = (a[7] == b[7]) && (raw[7] != a[7]);
            end
            2'd1: begin
                s   = {1'b0, a} + {1'b0, ~b} + 9'd1;
                raw = s[7:0];
                r.c = s[8];
                r.v = (a[7] != b[7]) && (raw[7] != a[7]);
            end
            2'd2:    raw = inv ? ~(a & b) : (a & b);
            default: raw = inv ? ~(a | b) : (a | b);
        endcase
        if (sh) begin
            r.c = raw[7];
            raw = raw << 1;
        end
        r.res = raw;
        r.z   = (raw == 8'h00);
        r.g   = (a > b);
        return r;
    endfunction

    function automatic out_t observed();
        return {result, carry, overflow, iszero, greaterthan};
    endfunction

    // One complete request/response transaction; all driving at negedge.
    task automatic run_op(input logic [1:0] o, input logic inv,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic sh, input int stall, output out_t got);
        int         lat;
        logic [4:0] exp_sc;
        lat = 0;
        while (!req_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("req_ready_before_req", req_ready, 1);
        op = o; invert = inv; A = a; B = b; req_valid = 1'b1;
`ifdef SERIAL_ALU_SHIFT_EN
        shl = sh;
`endif
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs: the latched request must be unaffected
        req_valid = 1'b0;
        A = 8'($urandom); B = 8'($urandom); op = 2'($urandom); invert = 1'($urandom);
`ifdef SERIAL_ALU_SHIFT_EN
        shl = 1'($urandom);
`endif
        exp_sc = {o, inv, (o == 2'd1), sh};
        check("slice_ctrl_first_bit", slice_ctrl, exp_sc);
        check("req_ready_in_run", req_ready, 0);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("rsp_latency", lat, WIDTH);
        got = observed();
        for (int k = 0; k < stall; k++) begin
            req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("done_hold_outputs", observed(), got);
            check("done_hold_rsp_valid", rsp_valid, 1);
            check("done_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_slice_ctrl", slice_ctrl, 0);
        check("idle_req_ready", req_ready, 1);
    endtask

    vec_t tbl[10];

    initial begin
        out_t got;
        out_t exp;
        int   bad;

        tbl[0] = '{2'd0, 1'b0, 8'h7F, 8'h01, 5, '{8'h80, 1'b0, 1'b1, 1'b0, 1'b1}};
        tbl[1] = '{2'd1, 1'b0, 8'h05, 8'h05, 0, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0}};
        tbl[2] = '{2'd1, 1'b0, 8'h03, 8'h05, 0, '{8'hFE, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[3] = '{2'd2, 1'b1, 8'hF0, 8'h3C, 0, '{8'hCF, 1'b0, 1'b0, 1'b0, 1'b1}};
        tbl[4] = '{2'd3, 1'b1, 8'hF0, 8'h3C, 1, '{8'h03, 1'b0, 1'b0, 1'b0, 1'b1}};
        tbl[5] = '{2'd0, 1'b0, 8'hFF, 8'h01, 0, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1}};
        tbl[6] = '{2'd1, 1'b0, 8'h80, 8'h01, 0, '{8'h7F, 1'b1, 1'b1, 1'b0, 1'b1}};
        tbl[7] = '{2'd2, 1'b0, 8'hFF, 8'h00, 0, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1}};
        tbl[8] = '{2'd0, 1'b1, 8'h10, 8'h20, 0, '{8'h30, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[9] = '{2'd3, 1'b0, 8'h00, 8'h00, 2, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0}};

        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        op = 2'd0; invert = 1'b0; A = 8'h00; B = 8'h00;
`ifdef SERIAL_ALU_SHIFT_EN
        shl = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_outputs", observed(), 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_req_ready", req_ready, 1);
        check("reset_slice_ctrl", slice_ctrl, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].op, tbl[i].inv, tbl[i].a, tbl[i].b, 1'b0, tbl[i].stall, got);
            check($sformatf("vec%0d_result", i), got.res, tbl[i].exp.res);
            check($sformatf("vec%0d_carry", i), got.c, tbl[i].exp.c);
            check($sformatf("vec%0d_overflow", i), got.v, tbl[i].exp.v);
            check($sformatf("vec%0d_iszero", i), got.z, tbl[i].exp.z);
            check($sformatf("vec%0d_greaterthan", i), got.g, tbl[i].exp.g);
        end

        // Randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            logic [1:0] ro;
            logic       ri;
            logic [7:0] ra;
            logic [7:0] rb;
            ro = 2'($urandom);
            ri = 1'($urandom);
            ra = 8'($urandom);
            rb = (i % 5 == 0) ? ra : 8'($urandom);
            exp = model(ro, ri, ra, rb, 1'b0);
            run_op(ro, ri, ra, rb, 1'b0, int'($urandom_range(0, 2)), got);
            check($sformatf("rand%0d op%0d a=%02h b=%02h", i, ro, ra, rb), got, exp);
        end

        // Reset while counter = 3: operation discarded, no response
        op = 2'd0; invert = 1'b0; A = 8'h55; B = 8'h22; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrun_reset_outputs", observed(), 0);
        check("midrun_reset_rsp_valid", rsp_valid, 0);
        check("midrun_reset_req_ready", req_ready, 1);
        check("midrun_reset_slice_ctrl", slice_ctrl, 0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (rsp_valid || !req_ready) bad++;
        end
        check("midrun_reset_no_response", bad, 0);
        run_op(2'd0, 1'b0, 8'h01, 8'h02, 1'b0, 0, got);
        check("after_reset_add", got, out_t'({8'h03, 1'b0, 1'b0, 1'b0, 1'b0}));

`ifdef SERIAL_ALU_SHIFT_EN
        run_op(2'd0, 1'b0, 8'h81, 8'h00, 1'b1, 0, got);
        check("shl_result", got.res, 8'h02);
        check("shl_carry", got.c, 1);
        check("shl_iszero", got.z, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/serial_alu_ctrl.md
SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 op  input  2  operation: 0 add, 1 sub, 2 and, 3 or.
REQ-007 invert  input  1  for and/or, inverts the result (nand/nor); ignored for add/sub.
REQ-008 A  input  WIDTH  first operand, unsigned/two's complement.
REQ-009 B  input  WIDTH  second operand.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  consumer accepts response.
REQ-012 result  output  WIDTH  operation result.
REQ-013 carry  output  1  final carry-out (add/sub; sub: 1 = no borrow); 0 for logic ops.
REQ-014 overflow  output  1  signed overflow (add/sub); 0 for logic ops.
REQ-015 iszero  output  1  result == 0.
REQ-016 greaterthan  output  1  unsigned A > B.
REQ-017 slice_ctrl  output  5  control word driven to the bit slice: [4:3] op, [2] invert, [1] carry-in, [0] shift.

Function
REQ-018 FSM states IDLE, RUN, DONE; req_ready SHALL equal (state == IDLE).
REQ-019 IDLE: req_valid && req_ready at an edge SHALL latch op, invert, A, B, clear bit counter, enter RUN.
REQ-020 RUN: one bit per cycle, LSB first, bit index = counter 0..WIDTH-1; counter SHALL increment each cycle.
REQ-021 Carry register SHALL initialise to 1 for sub, 0 otherwise; sub SHALL compute A + ~B + 1.
REQ-022 Each RUN cycle SHALL write slice output to result[counter] and update carry register with slice carry-out.
REQ-023 overflow SHALL equal carry-in XOR carry-out of bit WIDTH-1 for add/sub.
REQ-024 greaterthan SHALL be computed serially: gt <= (a & ~b) | (~(a ^ b) & gt), gt cleared at accept.
REQ-025 After bit WIDTH-1, FSM SHALL enter DONE; rsp_valid SHALL rise exactly WIDTH edges after the accepting edge.
REQ-026 DONE: rsp_valid high; result and flags SHALL hold stable until rsp_valid && rsp_ready, then IDLE.
REQ-027 Minimum request-to-request spacing SHALL be WIDTH+2 cycles; no request is accepted in RUN or DONE.
REQ-028 Operand input changes after acceptance SHALL NOT affect the result.
REQ-029 rsp_valid SHALL be 0 and slice_ctrl SHALL be 0 in IDLE.

Reset
REQ-030 reset assertion SHALL immediately force IDLE, counter 0, result 0, all flags 0, rsp_valid 0, req_ready 1.
REQ-031 Reset mid-RUN or mid-DONE SHALL discard the operation; no response is produced.

Configuration
REQ-032 Macro SERIAL_ALU_SHIFT_EN defined: input port shl (1 bit) SHALL exist, latched at accept; shl=1 places slice bit i into result[i+1], result[0]=0, original bit WIDTH-1 to carry; iszero evaluates the shifted result; slice_ctrl[0]=shl.
REQ-033 Macro undefined: no shl port, behaviour identical to shl=0, slice_ctrl[0]=0.

Structure
REQ-034 Package serial_alu_pkg SHALL hold op encodings (OP_ADD, OP_SUB, OP_AND, OP_OR), FSM state type, slice_ctrl field positions.
REQ-035 One sub-module alu_bit_slice (a, b, ctrl[4:0] -> sum/logic out, carry-out) SHALL be instantiated once.

Verification (WIDTH=8)
REQ-036 ADD 0x7F+0x01 -> result 0x80, overflow 1, carry 0, iszero 0, greaterthan 1, rsp_valid 8 edges after accept.
REQ-037 SUB 0x05-0x05 -> 0x00, iszero 1, carry 1; SUB 0x03-0x05 -> 0xFE, carry 0, greaterthan 0, overflow 0.
REQ-038 AND invert=1 0xF0,0x3C -> 0xCF; OR invert=1 0xF0,0x3C -> 0x03; carry 0, overflow 0.
REQ-039 rsp_ready low 5 cycles in DONE -> outputs stable, req_ready 0, concurrent req_valid ignored.
REQ-040 reset at counter=3 -> all outputs 0, req_ready 1; following ADD 0x01+0x02 -> 0x03.
REQ-041 With SERIAL_ALU_SHIFT_EN: ADD 0x81+0x00, shl=1 -> result 0x02, carry 1, iszero 0.
